ddfs_lut_ctrl: RTL

Sequencer for the DDFS sine path. It owns the quarter-wave `sin_lut` (one synchronous read port, MAX_LUT+1 entries, entry 0 = 0, entry MAX_LUT = full scale). It generates a full-period address sequence from a phase accumulator, reconstructs the sign of the lower half-wave after the LUT latency, and emits one sample per accumulator carry. It sits between the frequency-control interface and the DAC/output stage.

---
 rtl/ddfs_lut_ctrl_if.sv | 28 ++
 rtl/ddfs_lut_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ddfs_lut_ctrl_if.sv
// Control, tuning-word handshake, LUT port and sample output of the DDFS sine sequencer.
// master = frequency-control / LUT / output side, slave = ddfs_lut_ctrl.
interface ddfs_lut_ctrl_if #(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 7,
  parameter int PHASE_WIDTH = 24
);
  logic                   start;
  logic                   stop;
  logic [PHASE_WIDTH-1:0] ftw_in;
  logic                   ftw_valid;
  logic                   ftw_ready;
  logic [ADDR_WIDTH-1:0]  lut_addr;
  logic [DATA_WIDTH-1:0]  lut_q;
  logic [DATA_WIDTH:0]    sample_out;
  logic                   sample_valid;
  logic                   period_tick;
  logic                   busy;

  modport master (
    output start, stop, ftw_in, ftw_valid, lut_q,
    input  ftw_ready, lut_addr, sample_out, sample_valid, period_tick, busy
  );
  modport slave (
    input  start, stop, ftw_in, ftw_valid, lut_q,
    output ftw_ready, lut_addr, sample_out, sample_valid, period_tick, busy
  );
endinterface

// File: rtl/ddfs_lut_ctrl.sv
// DDFS quarter-wave LUT sequencer: phase accumulator, 4-quadrant addressing, sign restore.
// Optional DDFS_CTRL_OFFSET_BINARY_EN: emit offset-binary samples (zero = 2^DATA_WIDTH).
module ddfs_lut_ctrl #(
  parameter int                     DATA_WIDTH  = 12,
  parameter int                     ADDR_WIDTH  = 7,
  parameter int                     MAX_LUT     = 85,
  parameter int                     PHASE_WIDTH = 24,
  parameter logic [PHASE_WIDTH-1:0] FTW_RESET   = '0
) (
  input logic            clk,
  input logic            rst,
  ddfs_lut_ctrl_if.slave bus
);

`ifdef DDFS_CTRL_OFFSET_BINARY_EN
  localparam logic [DATA_WIDTH:0] ZERO_CODE = {1'b1, {DATA_WIDTH{1'b0}}};
`else
  localparam logic [DATA_WIDTH:0] ZERO_CODE = '0;
`endif
  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(MAX_LUT - 1);
  localparam logic [ADDR_WIDTH-1:0] A_MAX  = ADDR_WIDTH'(MAX_LUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_e;

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d, ftw_q, ftw_d, pend_q, pend_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [ADDR_WIDTH-1:0]  k_q, k_d, addr_q, addr_d;
  logic [1:0]             quad_q, quad_d;
  logic [2:1]             vld_pipe_q, neg_pipe_q;
  logic                   tick_q, tick_d;
  logic [DATA_WIDTH:0]    samp_q, samp_d, mag;
  logic                   svld_q;
  logic [PHASE_WIDTH:0]   acc_sum;
  logic                   carry, at_origin, ftw_take, issue;

  assign acc_sum   = {1'b0, acc_q} + {1'b0, ftw_q};
  assign carry     = acc_sum[PHASE_WIDTH];
  assign at_origin = (quad_q == 2'd0) && (k_q == '0);
  assign ftw_take  = bus.ftw_valid && !pend_vld_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ftw_d      = ftw_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    k_d        = k_q;
    quad_d     = quad_q;
    addr_d     = addr_q;
    issue      = 1'b0;
    tick_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A word still pending from the last run is applied before new ones are taken
        if (pend_vld_q) begin
          ftw_d      = pend_q;
          pend_vld_d = 1'b0;
        end else if (ftw_take) begin
          ftw_d = bus.ftw_in;
        end
        if (bus.start && !bus.stop) begin
          state_d = S_RUN;
          acc_d   = '0;
          k_d     = '0;
          quad_d  = 2'd0;
        end
      end
      default: begin
        acc_d = acc_sum[PHASE_WIDTH-1:0];
        if (ftw_take) begin
          pend_d     = bus.ftw_in;
          pend_vld_d = 1'b1;
        end
        if (state_q == S_RUN && bus.stop) state_d = S_STOPPING;
        if (state_q == S_STOPPING && ftw_q == '0) state_d = S_IDLE;
        if (carry) begin
          if (state_q == S_STOPPING && at_origin) begin
            state_d = S_IDLE;
          end else begin
            issue  = 1'b1;
            tick_d = at_origin;
            addr_d = quad_q[0] ? A_MAX - k_q : k_q;
            if (k_q == K_LAST) begin
              k_d    = '0;
              quad_d = quad_q + 2'd1;
            end else begin
              k_d = k_q + ADDR_WIDTH'(1);
            end
          end
          // Rate changes only at the period boundary so the waveform stays continuous
          if (at_origin && pend_vld_q) begin
            ftw_d      = pend_q;
            pend_vld_d = 1'b0;
          end
        end
      end
    endcase
  end

  // Lower half-wave: negate the LUT magnitude once it emerges from the LUT register
  assign mag    = {1'b0, bus.lut_q};
  assign samp_d = (neg_pipe_q[2] ? -mag : mag) + ZERO_CODE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      ftw_q      <= FTW_RESET;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      k_q        <= '0;
      quad_q     <= 2'd0;
      addr_q     <= '0;
      vld_pipe_q <= '0;
      neg_pipe_q <= '0;
      tick_q     <= 1'b0;
      samp_q     <= ZERO_CODE;
      svld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ftw_q      <= ftw_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      k_q        <= k_d;
      quad_q     <= quad_d;
      addr_q     <= addr_d;
      vld_pipe_q <= {vld_pipe_q[1], issue};
      neg_pipe_q <= {neg_pipe_q[1], quad_q[1]};
      tick_q     <= tick_d;
      svld_q     <= vld_pipe_q[2];
      if (vld_pipe_q[2]) samp_q <= samp_d;
    end
  end

  assign bus.lut_addr     = addr_q;
  assign bus.period_tick  = tick_q;
  assign bus.sample_valid = svld_q;
  assign bus.sample_out   = samp_q;
  assign bus.ftw_ready    = !pend_vld_q;
  assign bus.busy         = (state_q != S_IDLE) || (|vld_pipe_q);

endmodule
